// File: rtl/sha2_message_build_param.sv
// rtl/sha2_message_build_param.sv - SHA-2 message block builder with '1'-bit, zero-fill and length padding
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   en                   block enable; 0 drops all readies/valids and freezes state
//   sync_rst             synchronous return to IDLE, same effect as nrst
//   data_in*             message words (first message bit in the MSB), last marks final word
//   cfg_*                per-message bit length and scheme (0/2/3: SHA-2 pad, 1: raw)
//   data_out*            BLOCK_W-bit blocks, last marks the final block of a message
//   status_err           sticky flag: data_in_last arrived on an unexpected word

module sha2_message_build_param #(
    parameter int DATA_IN_W = 512,
    parameter int BLOCK_W   = 512
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 sync_rst,
    input  logic [DATA_IN_W-1:0] data_in,
    input  logic                 data_in_last,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    input  logic [63:0]          cfg_size,
    input  logic [1:0]           cfg_scheme,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [BLOCK_W-1:0]   data_out,
    output logic                 data_out_last,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 status_err
);

    localparam int LEN_W   = BLOCK_W / 8;
    localparam int WORDS   = BLOCK_W / DATA_IN_W;
    localparam int WPTR_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int R_W     = $clog2(BLOCK_W);
    localparam logic [BLOCK_W-1:0] TOP_BIT = {1'b1, {(BLOCK_W-1){1'b0}}};
    localparam logic [R_W-1:0]     PAD_MAX = R_W'(BLOCK_W - LEN_W - 1);

    typedef enum logic [2:0] {IDLE, FILL, PAD, EMIT, DRAIN} state_t;

    state_t              state_q, state_d, nxt_q, nxt_d;
    logic [BLOCK_W-1:0]  buf_q, buf_d;
    logic [WPTR_W-1:0]   wptr_q, wptr_d;
    logic [63:0]         remaining_q, remaining_d;
    logic [63:0]         size_q, size_d;
    logic                raw_q, raw_d;
    logic                last_q, last_d;
    logic                lead_q, lead_d;
    logic                drain_q, drain_d;
    logic                err_q, err_d;

    logic [DATA_IN_W-1:0] word_m;
    logic                 is_final;
    logic                 blk_full;
    logic [R_W-1:0]       r;
    logic [BLOCK_W-1:0]   len_blk;
    int                   slot_sh;

    // Keep only the top 'remaining' bits; shifts of DATA_IN_W or more keep the whole word.
    assign word_m   = data_in & ~({DATA_IN_W{1'b1}} >> remaining_q);
    assign is_final = (remaining_q <= 64'(DATA_IN_W));
    assign blk_full = (wptr_q == WPTR_W'(WORDS - 1));
    assign r        = size_q[R_W-1:0];
    assign len_blk  = BLOCK_W'(LEN_W'(size_q));
    assign slot_sh  = (WORDS - 1 - int'(wptr_q)) * DATA_IN_W;

    assign cfg_ready      = en && (state_q == IDLE);
    assign data_in_ready  = en && ((state_q == FILL) || (state_q == DRAIN));
    assign data_out_valid = en && (state_q == EMIT);
    assign data_out       = buf_q;
    assign data_out_last  = last_q;
    assign status_err     = err_q;

    always_comb begin
        state_d     = state_q;
        nxt_d       = nxt_q;
        buf_d       = buf_q;
        wptr_d      = wptr_q;
        remaining_d = remaining_q;
        size_d      = size_q;
        raw_d       = raw_q;
        last_d      = last_q;
        lead_d      = lead_q;
        drain_d     = drain_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    size_d      = cfg_size;
                    raw_d       = (cfg_scheme == 2'd1);
                    remaining_d = cfg_size;
                    wptr_d      = '0;
                    buf_d       = '0;
                    last_d      = 1'b0;
                    drain_d     = 1'b0;
                    if (cfg_size == 64'd0) begin
                        lead_d  = 1'b1;
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (data_in_valid) begin
                    // Buffer is cleared per block, so OR-ing the word into its slot is enough.
                    buf_d = buf_q | (BLOCK_W'(word_m) << slot_sh);
                    if (data_in_last && !is_final) begin
                        err_d = 1'b1;
                    end
                    if (is_final) begin
                        // A missing last means extra words follow and must be swallowed.
                        drain_d = !data_in_last;
                        wptr_d  = '0;
                        state_d = EMIT;
                        if (raw_q) begin
                            last_d = 1'b1;
                            nxt_d  = IDLE;
                        end else if (r == '0) begin
                            last_d = 1'b0;
                            lead_d = 1'b1;
                            nxt_d  = PAD;
                        end else begin
                            buf_d = buf_d | (TOP_BIT >> r);
                            if (r <= PAD_MAX) begin
                                buf_d  = buf_d | len_blk;
                                last_d = 1'b1;
                                nxt_d  = IDLE;
                            end else begin
                                last_d = 1'b0;
                                lead_d = 1'b0;
                                nxt_d  = PAD;
                            end
                        end
                    end else begin
                        remaining_d = remaining_q - 64'(DATA_IN_W);
                        if (blk_full) begin
                            wptr_d  = '0;
                            last_d  = 1'b0;
                            nxt_d   = FILL;
                            state_d = EMIT;
                        end else begin
                            wptr_d = wptr_q + WPTR_W'(1);
                        end
                    end
                end
            end
            PAD: begin
                buf_d   = (lead_q ? TOP_BIT : '0) | len_blk;
                last_d  = 1'b1;
                nxt_d   = IDLE;
                state_d = EMIT;
            end
            EMIT: begin
                if (data_out_ready) begin
                    buf_d   = '0;
                    last_d  = 1'b0;
                    state_d = ((nxt_q == IDLE) && drain_q) ? DRAIN : nxt_q;
                end
            end
            DRAIN: begin
                // Any word here is beyond the expected count, so its last flag is misplaced.
                if (data_in_valid && data_in_last) begin
                    err_d   = 1'b1;
                    drain_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            nxt_q       <= IDLE;
            buf_q       <= '0;
            wptr_q      <= '0;
            remaining_q <= '0;
            size_q      <= '0;
            raw_q       <= 1'b0;
            last_q      <= 1'b0;
            lead_q      <= 1'b0;
            drain_q     <= 1'b0;
            err_q       <= 1'b0;
        end else if (sync_rst) begin
            state_q     <= IDLE;
            nxt_q       <= IDLE;
            buf_q       <= '0;
            wptr_q      <= '0;
            remaining_q <= '0;
            size_q      <= '0;
            raw_q       <= 1'b0;
            last_q      <= 1'b0;
            lead_q      <= 1'b0;
            drain_q     <= 1'b0;
            err_q       <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            buf_q       <= buf_d;
            wptr_q      <= wptr_d;
            remaining_q <= remaining_d;
            size_q      <= size_d;
            raw_q       <= raw_d;
            last_q      <= last_d;
            lead_q      <= lead_d;
            drain_q     <= drain_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_sha2_message_build_param.sv
// tb/tb_sha2_message_build_param.sv - directed bench for sha2_message_build_param in three geometries

module tb_sha2_message_build_param;

    logic clk = 1'b0;
    logic nrst, en, sync_rst;

    logic [511:0]  a_data_in;
    logic          a_data_in_last, a_data_in_valid, a_data_in_ready;
    logic [63:0]   a_cfg_size;
    logic [1:0]    a_cfg_scheme;
    logic          a_cfg_valid, a_cfg_ready;
    logic [511:0]  a_data_out;
    logic          a_data_out_last, a_data_out_valid, a_data_out_ready, a_status_err;

    logic [31:0]   b_data_in;
    logic          b_data_in_last, b_data_in_valid, b_data_in_ready;
    logic [63:0]   b_cfg_size;
    logic [1:0]    b_cfg_scheme;
    logic          b_cfg_valid, b_cfg_ready;
    logic [511:0]  b_data_out;
    logic          b_data_out_last, b_data_out_valid, b_data_out_ready, b_status_err;

    logic [63:0]   c_data_in;
    logic          c_data_in_last, c_data_in_valid, c_data_in_ready;
    logic [63:0]   c_cfg_size;
    logic [1:0]    c_cfg_scheme;
    logic          c_cfg_valid, c_cfg_ready;
    logic [1023:0] c_data_out;
    logic          c_data_out_last, c_data_out_valid, c_data_out_ready, c_status_err;

    int n_cmp = 0;
    int n_bad = 0;
    int b_acc = 0;
    int base;
    logic [511:0]  blk;
    logic [1023:0] blk_c;
    logic          lst;

    localparam logic [511:0] ABC512 = {32'h61626380, 416'h0, 64'h18};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b_data_in_valid && b_data_in_ready) b_acc <= b_acc + 1;
    end

    sha2_message_build_param #(.DATA_IN_W(512), .BLOCK_W(512)) u_a (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .data_in(a_data_in), .data_in_last(a_data_in_last),
        .data_in_valid(a_data_in_valid), .data_in_ready(a_data_in_ready),
        .cfg_size(a_cfg_size), .cfg_scheme(a_cfg_scheme),
        .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .data_out(a_data_out), .data_out_last(a_data_out_last),
        .data_out_valid(a_data_out_valid), .data_out_ready(a_data_out_ready),
        .status_err(a_status_err)
    );

    sha2_message_build_param #(.DATA_IN_W(32), .BLOCK_W(512)) u_b (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .data_in(b_data_in), .data_in_last(b_data_in_last),
        .data_in_valid(b_data_in_valid), .data_in_ready(b_data_in_ready),
        .cfg_size(b_cfg_size), .cfg_scheme(b_cfg_scheme),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .data_out(b_data_out), .data_out_last(b_data_out_last),
        .data_out_valid(b_data_out_valid), .data_out_ready(b_data_out_ready),
        .status_err(b_status_err)
    );

    sha2_message_build_param #(.DATA_IN_W(64), .BLOCK_W(1024)) u_c (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .data_in(c_data_in), .data_in_last(c_data_in_last),
        .data_in_valid(c_data_in_valid), .data_in_ready(c_data_in_ready),
        .cfg_size(c_cfg_size), .cfg_scheme(c_cfg_scheme),
        .cfg_valid(c_cfg_valid), .cfg_ready(c_cfg_ready),
        .data_out(c_data_out), .data_out_last(c_data_out_last),
        .data_out_valid(c_data_out_valid), .data_out_ready(c_data_out_ready),
        .status_err(c_status_err)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic a_cfg(input logic [63:0] sz, input logic [1:0] sch);
        int n = 0;
        a_cfg_size = sz; a_cfg_scheme = sch; a_cfg_valid = 1'b1;
        while (!a_cfg_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk1("a_cfg_handshake", a_cfg_ready, 1'b1);
        @(posedge clk); #1;
        a_cfg_valid = 1'b0;
    endtask

    task automatic a_send(input logic [511:0] d, input logic l);
        int n = 0;
        a_data_in = d; a_data_in_last = l; a_data_in_valid = 1'b1;
        while (!a_data_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk1("a_data_handshake", a_data_in_ready, 1'b1);
        @(posedge clk); #1;
        a_data_in_valid = 1'b0;
    endtask

    task automatic a_get(output logic [511:0] b, output logic l);
        int n = 0;
        while (!a_data_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk1("a_out_timeout", a_data_out_valid, 1'b1);
        b = a_data_out; l = a_data_out_last;
        @(posedge clk); #1;
    endtask

    task automatic b_cfg(input logic [63:0] sz, input logic [1:0] sch);
        int n = 0;
        b_cfg_size = sz; b_cfg_scheme = sch; b_cfg_valid = 1'b1;
        while (!b_cfg_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk1("b_cfg_handshake", b_cfg_ready, 1'b1);
        @(posedge clk); #1;
        b_cfg_valid = 1'b0;
    endtask

    task automatic b_send(input logic [31:0] d, input logic l);
        int n = 0;
        b_data_in = d; b_data_in_last = l; b_data_in_valid = 1'b1;
        while (!b_data_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk1("b_data_handshake", b_data_in_ready, 1'b1);
        @(posedge clk); #1;
        b_data_in_valid = 1'b0;
    endtask

    task automatic b_get(output logic [511:0] b, output logic l);
        int n = 0;
        while (!b_data_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk1("b_out_timeout", b_data_out_valid, 1'b1);
        b = b_data_out; l = b_data_out_last;
        @(posedge clk); #1;
    endtask

    task automatic c_cfg(input logic [63:0] sz, input logic [1:0] sch);
        int n = 0;
        c_cfg_size = sz; c_cfg_scheme = sch; c_cfg_valid = 1'b1;
        while (!c_cfg_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk1("c_cfg_handshake", c_cfg_ready, 1'b1);
        @(posedge clk); #1;
        c_cfg_valid = 1'b0;
    endtask

    task automatic c_send(input logic [63:0] d, input logic l);
        int n = 0;
        c_data_in = d; c_data_in_last = l; c_data_in_valid = 1'b1;
        while (!c_data_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk1("c_data_handshake", c_data_in_ready, 1'b1);
        @(posedge clk); #1;
        c_data_in_valid = 1'b0;
    endtask

    task automatic c_get(output logic [1023:0] b, output logic l);
        int n = 0;
        while (!c_data_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk1("c_out_timeout", c_data_out_valid, 1'b1);
        b = c_data_out; l = c_data_out_last;
        @(posedge clk); #1;
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1; sync_rst = 1'b0;
        a_data_in = '0; a_data_in_last = 1'b0; a_data_in_valid = 1'b0;
        a_cfg_size = '0; a_cfg_scheme = '0; a_cfg_valid = 1'b0; a_data_out_ready = 1'b1;
        b_data_in = '0; b_data_in_last = 1'b0; b_data_in_valid = 1'b0;
        b_cfg_size = '0; b_cfg_scheme = '0; b_cfg_valid = 1'b0; b_data_out_ready = 1'b0;
        c_data_in = '0; c_data_in_last = 1'b0; c_data_in_valid = 1'b0;
        c_cfg_size = '0; c_cfg_scheme = '0; c_cfg_valid = 1'b0; c_data_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk1("rst_cfg_ready", a_cfg_ready, 1'b1);
        chk1("rst_out_valid", a_data_out_valid, 1'b0);
        chk1("rst_in_ready", a_data_in_ready, 1'b0);
        chk1("rst_out_last", a_data_out_last, 1'b0);
        chk("rst_data_out", a_data_out, 512'h0);
        chk1("rst_status_err", a_status_err, 1'b0);
        nrst = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; #1;
        chk1("en0_cfg_ready", a_cfg_ready, 1'b0);
        en = 1'b1; #1;

        // "abc", single 512-bit word with junk below the message
        a_cfg(64'd24, 2'd0);
        a_send({24'h616263, {61{8'hA5}}}, 1'b1);
        a_get(blk, lst);
        chk("a_abc_block", blk, ABC512);
        chk1("a_abc_last", lst, 1'b1);

        // 448 bits: pad bit fits, length spills to a second block
        a_cfg(64'd448, 2'd0);
        a_send({{56{8'h3C}}, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
        a_get(blk, lst);
        chk("a_448_blk1", blk, {{56{8'h3C}}, 8'h80, 56'h0});
        chk1("a_448_last1", lst, 1'b0);
        a_get(blk, lst);
        chk("a_448_blk2", blk, {448'h0, 64'h1C0});
        chk1("a_448_last2", lst, 1'b1);

        // 512 bits: block exactly full, lead '1' moves to the pad block
        a_cfg(64'd512, 2'd2);
        a_send({64{8'h5A}}, 1'b1);
        a_get(blk, lst);
        chk("a_512_blk1", blk, {64{8'h5A}});
        chk1("a_512_last1", lst, 1'b0);
        a_get(blk, lst);
        chk("a_512_blk2", blk, {8'h80, 440'h0, 64'h200});
        chk1("a_512_last2", lst, 1'b1);

        // Empty message
        a_cfg(64'd0, 2'd0);
        a_get(blk, lst);
        chk("a_empty_blk", blk, {8'h80, 504'h0});
        chk1("a_empty_last", lst, 1'b1);

        // Raw scheme: masked data, zero fill, no pad
        a_cfg(64'd24, 2'd1);
        a_send({24'h616263, {61{8'hA5}}}, 1'b1);
        a_get(blk, lst);
        chk("a_raw_blk", blk, {24'h616263, 488'h0});
        chk1("a_raw_last", lst, 1'b1);

        // 32-bit words, output stalled: one word taken, block held stable
        base = b_acc;
        b_cfg(64'd24, 2'd0);
        b_send({24'h616263, 8'hEE}, 1'b1);
        b_get(blk, lst);
        chk("b_abc_block", blk, ABC512);
        chk1("b_abc_last", lst, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("b_stall_data", b_data_out, ABC512);
            chk1("b_stall_valid", b_data_out_valid, 1'b1);
            chk1("b_stall_in_ready", b_data_in_ready, 1'b0);
            @(posedge clk); #1;
        end
        chk("b_words_accepted", 512'(b_acc - base), 512'd1);
        en = 1'b0; #1;
        chk1("b_en0_valid", b_data_out_valid, 1'b0);
        chk("b_en0_hold", b_data_out, ABC512);
        en = 1'b1; #1;
        b_data_out_ready = 1'b1;
        @(posedge clk); #1;
        chk1("b_after_consume", b_data_out_valid, 1'b0);

        // Early data_in_last on word 2 of 3, extra word dropped until last
        b_cfg(64'd96, 2'd0);
        b_send(32'h11111111, 1'b0);
        b_send(32'h22222222, 1'b1);
        chk1("b_err_set", b_status_err, 1'b1);
        b_send(32'h33333333, 1'b0);
        b_get(blk, lst);
        chk("b_96_block", blk, {32'h11111111, 32'h22222222, 32'h33333333, 8'h80, 344'h0, 64'h60});
        chk1("b_96_last", lst, 1'b1);
        b_send(32'h44444444, 1'b1);
        chk1("b_drain_idle", b_cfg_ready, 1'b1);
        sync_rst = 1'b1;
        @(posedge clk); #1;
        sync_rst = 1'b0;
        chk1("b_sync_rst_err", b_status_err, 1'b0);

        // nrst mid-FILL discards the partial block
        b_cfg(64'd96, 2'd0);
        b_send(32'hCAFEF00D, 1'b0);
        nrst = 1'b0; #1;
        chk1("b_midrst_valid", b_data_out_valid, 1'b0);
        chk1("b_midrst_cfg_ready", b_cfg_ready, 1'b1);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        chk1("b_no_residual", b_data_out_valid, 1'b0);
        b_cfg(64'd24, 2'd0);
        b_send({24'h616263, 8'h00}, 1'b1);
        b_get(blk, lst);
        chk("b_post_rst_block", blk, ABC512);
        chk1("b_post_rst_last", lst, 1'b1);

        // 1024-bit block, 64-bit words, 128-bit length field
        c_cfg(64'd24, 2'd0);
        c_send({24'h616263, 40'hDEADBEEF12}, 1'b1);
        c_get(blk_c, lst);
        chk("c_abc_hi", blk_c[1023:512], {32'h61626380, 480'h0});
        chk("c_abc_lo", blk_c[511:0], {384'h0, 128'h18});
        chk1("c_abc_last", lst, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
